// File: rtl/mul_wb_ctrl_pkg.sv
// Shared constants and types for the multiplier writeback controller:
// M-extension decode, register index width and the tag/result record layouts.
package mul_wb_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [31:0] INST_MUL      = 32'h02000033;
  localparam logic [31:0] INST_MULH     = 32'h02001033;
  localparam logic [31:0] INST_MULHSU   = 32'h02002033;
  localparam logic [31:0] INST_MULHU    = 32'h02003033;
  localparam logic [31:0] INST_MUL_MASK = 32'hfe00707f;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } tag_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  // Same four-way decode the multiplier uses, so tags and results stay paired.
  function automatic logic is_mul_op(input logic [31:0] inst);
    logic [31:0] m;
    m = inst & INST_MUL_MASK;
    return (m == INST_MUL) || (m == INST_MULH) ||
           (m == INST_MULHSU) || (m == INST_MULHU);
  endfunction

  function automatic logic src_match(input logic [REG_ADDR_W-1:0] rs1,
                                     input logic [REG_ADDR_W-1:0] rs2,
                                     input logic [REG_ADDR_W-1:0] rd);
    return ((rs1 != '0) && (rs1 == rd)) || ((rs2 != '0) && (rs2 == rd));
  endfunction

endpackage

// File: rtl/mul_wb_fifo.sv
// Small power-of-two FIFO with occupancy count; head is shown combinationally
// and the last popped word is held on the output while empty.
module mul_wb_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 37,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            data_o,
  output logic [CW-1:0]               count_o,
  output logic [DEPTH-1:0]            occ_o,
  output logic [DEPTH-1:0][WIDTH-1:0] mem_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q;
  logic [PW-1:0]               rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic [WIDTH-1:0]            last_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign count_o = count_q;
  assign mem_o   = mem_q;

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] off;
    occ_o = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr_q;
      occ_o[i] = (CW'(off) < count_q);
    end
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/mul_wb_ctrl.sv
// Writeback companion of the multiplier: tag pipe, result buffer and stall.
// Optional issue-stage RAW scoreboard enabled by MUL_WB_SCOREBOARD_EN.
module mul_wb_ctrl
  import mul_wb_ctrl_pkg::*;
#(
  parameter int MULT_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  issue_valid_i,
  input  logic [31:0]           issue_opcode_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       mul_value_i,
  input  logic                  wb_ready_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]       wb_value_o,
  output logic                  stall_o,
  output logic                  busy_o,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  hazard_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                                    issue_mul;
  logic [MULT_STAGES-1:0]                  stage_valid;
  logic [MULT_STAGES-1:0][REG_ADDR_W-1:0]  stage_rd;
  logic                                    consumed_q;
  logic                                    capture;
  logic                                    push;
  logic                                    pop;
  wb_entry_t                               entry_in;
  wb_entry_t                               head;
  logic [CW-1:0]                           count;
  logic [FIFO_DEPTH-1:0]                   occ;
  logic [FIFO_DEPTH-1:0][WB_ENTRY_W-1:0]   mem_view;

  assign issue_mul = issue_valid_i && is_mul_op(issue_opcode_i);

  // Tags advance on exactly the edges the multiplier datapath advances.
  for (genvar k = 0; k < MULT_STAGES; k++) begin : g_tag
    tag_t tag_d;
    tag_t tag_q;
    if (k == 0) begin : g_first
      assign tag_d = '{valid: issue_mul, rd: issue_rd_i};
    end else begin : g_next
      assign tag_d = '{valid: stage_valid[k-1], rd: stage_rd[k-1]};
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)      tag_q <= '0;
      else if (flush_i) tag_q <= '0;
      else if (!hold_i) tag_q <= tag_d;
    end
    assign stage_valid[k] = tag_q.valid;
    assign stage_rd[k]    = tag_q.rd;
  end

  // consumed blocks a second capture of the same result while the pipe is held.
  assign capture = stage_valid[MULT_STAGES-1] && !consumed_q && !flush_i;
  assign push    = capture && (stage_rd[MULT_STAGES-1] != '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      consumed_q <= 1'b0;
    else if (flush_i) consumed_q <= 1'b0;
    else if (!hold_i) consumed_q <= 1'b0;
    else if (capture) consumed_q <= 1'b1;
  end

  assign entry_in = '{rd: stage_rd[MULT_STAGES-1], value: mul_value_i};

  // Writeback handshake: an entry transfers on a clock edge where wb_valid_o
  // and wb_ready_i are both high; wb_valid_o never depends on wb_ready_i.
  assign pop = wb_valid_o && wb_ready_i;

  mul_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .data_i  (entry_in),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .occ_o   (occ),
    .mem_o   (mem_view)
  );

  assign wb_valid_o = (count != '0);
  assign wb_rd_o    = head.rd;
  assign wb_value_o = head.value;
  assign stall_o    = (count >= CW'(FIFO_DEPTH - 1));
  assign busy_o     = (|stage_valid) || (count != '0);

`ifdef MUL_WB_SCOREBOARD_EN
  logic hazard;
  logic unused_view;

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < MULT_STAGES; k++) begin
      if (stage_valid[k] && src_match(rs1_i, rs2_i, stage_rd[k])) hazard = 1'b1;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (occ[i] && src_match(rs1_i, rs2_i, mem_view[i][WB_ENTRY_W-1 -: REG_ADDR_W]))
        hazard = 1'b1;
    end
  end

  assign hazard_o    = hazard;
  assign unused_view = ^mem_view;
`else
  logic unused_sb;

  assign hazard_o  = 1'b0;
  assign unused_sb = ^{rs1_i, rs2_i, occ, mem_view, stage_rd};
`endif

endmodule

// File: tb/tb_mul_wb_ctrl.sv
// Directed bench for mul_wb_ctrl: vector table plus multi-cycle sequences.
module tb_mul_wb_ctrl;
  import mul_wb_ctrl_pkg::*;

`ifdef MUL_WB_SCOREBOARD_EN
  localparam logic SB_EN = 1'b1;
`else
  localparam logic SB_EN = 1'b0;
`endif

  localparam logic [31:0] OP_ADD = 32'h00000033;
  localparam logic [31:0] OP_DIV = 32'h02004033;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_opcode = '0;
  logic [4:0]  issue_rd = '0;
  logic        hold;
  logic        hold_drv = 1'b0;
  logic        stall_link = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] mul_value;
  logic        wb_ready = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic        stall;
  logic        busy;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        hazard;

  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] mv1;
  logic [31:0] mv2;

  int n_vec = 0;
  int n_err = 0;
  logic sb_en = 1'b0;
  logic [36:0] exp_q[$];

  // clock / reset / multiplier stand-in
  always #5 clk = ~clk;

  assign hold = hold_drv | (stall_link & stall);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mv1 <= '0;
      mv2 <= '0;
    end else if (!hold) begin
      mv1 <= op_a * op_b;
      mv2 <= mv1;
    end
  end
  assign mul_value = mv2;

  mul_wb_ctrl #(.MULT_STAGES(2), .FIFO_DEPTH(2)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .issue_valid_i  (issue_valid),
    .issue_opcode_i (issue_opcode),
    .issue_rd_i     (issue_rd),
    .hold_i         (hold),
    .flush_i        (flush),
    .mul_value_i    (mul_value),
    .wb_ready_i     (wb_ready),
    .wb_valid_o     (wb_valid),
    .wb_rd_o        (wb_rd),
    .wb_value_o     (wb_value),
    .stall_o        (stall),
    .busy_o         (busy),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .hazard_o       (hazard)
  );

  // driver tasks and checks
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_issue(input logic v, input logic [31:0] op, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
    issue_valid  = v;
    issue_opcode = op;
    issue_rd     = rd;
    op_a         = a;
    op_b         = b;
  endtask

  task automatic idle();
    set_issue(1'b0, 32'd0, 5'd0, 32'd0, 32'd0);
  endtask

  // One clock: scoreboard the writeback mid-cycle, then step past the edge.
  task automatic cycle();
    logic [36:0] e;
    #2;
    if (sb_en && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_wb", 64'({wb_rd, wb_value}), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wb_entry", 64'({wb_rd, wb_value}), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        issue;
    logic [31:0] op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
    logic        exp_busy;
    logic        exp_stall;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, INST_MUL,     5'd5,  32'd7,  32'd6,  1'b0, 1'b0, 5'd0,  32'd0,   1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b0, 1'b0, 5'd0,  32'd0,   1'b1, 1'b0};
    tbl[2]  = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b0, 1'b1, 5'd5,  32'd42,  1'b1, 1'b1};
    tbl[3]  = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b1, 1'b0, 5'd5,  32'd42,  1'b0, 1'b0};
    tbl[4]  = '{1'b1, OP_ADD,       5'd7,  32'd1,  32'd1,  1'b0, 1'b0, 5'd5,  32'd42,  1'b0, 1'b0};
    tbl[5]  = '{1'b1, OP_DIV,       5'd7,  32'd1,  32'd1,  1'b0, 1'b0, 5'd5,  32'd42,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, INST_MULHU,   5'd6,  32'd3,  32'd5,  1'b0, 1'b0, 5'd5,  32'd42,  1'b1, 1'b0};
    tbl[7]  = '{1'b1, INST_MULHSU,  5'd8,  32'd2,  32'd9,  1'b0, 1'b0, 5'd5,  32'd42,  1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b0, 1'b1, 5'd6,  32'd15,  1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b1, 1'b1, 5'd8,  32'd18,  1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b1, 1'b0, 5'd8,  32'd18,  1'b0, 1'b0};
    tbl[11] = '{1'b1, INST_MULH,    5'd0,  32'd4,  32'd4,  1'b0, 1'b0, 5'd8,  32'd18,  1'b1, 1'b0};
    tbl[12] = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b0, 1'b0, 5'd8,  32'd18,  1'b1, 1'b0};
    tbl[13] = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b0, 1'b0, 5'd8,  32'd18,  1'b0, 1'b0};
    tbl[14] = '{1'b1, 32'h02c58633, 5'd12, 32'd10, 32'd10, 1'b0, 1'b0, 5'd8,  32'd18,  1'b1, 1'b0};
    tbl[15] = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b0, 1'b0, 5'd8,  32'd18,  1'b1, 1'b0};
    tbl[16] = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b0, 1'b1, 5'd12, 32'd100, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 32'd0,        5'd0,  32'd0,  32'd0,  1'b1, 1'b0, 5'd12, 32'd100, 1'b0, 1'b0};

    // reset state
    @(posedge clk);
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_rd",    64'(wb_rd),    64'd0);
    chk("rst_wb_value", 64'(wb_value), 64'd0);
    chk("rst_stall",    64'(stall),    64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_hazard",   64'(hazard),   64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // vector table: decode, latency, pop, rd==0 discard, hold-last-value
    for (int i = 0; i < 18; i++) begin
      set_issue(tbl[i].issue, tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b);
      wb_ready = tbl[i].ready;
      cycle();
      chk($sformatf("v%0d_wb_valid", i), 64'(wb_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("v%0d_wb_rd", i),    64'(wb_rd),    64'(tbl[i].exp_rd));
      chk($sformatf("v%0d_wb_value", i), 64'(wb_value), 64'(tbl[i].exp_val));
      chk($sformatf("v%0d_busy", i),     64'(busy),     64'(tbl[i].exp_busy));
      chk($sformatf("v%0d_stall", i),    64'(stall),    64'(tbl[i].exp_stall));
    end
    idle();
    wb_ready = 1'b0;

    // hold while the tag sits in the last stage: exactly one capture
    set_issue(1'b1, INST_MUL, 5'd5, 32'd7, 32'd6);
    cycle();
    idle();
    cycle();
    hold_drv = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk($sformatf("hold%0d_wb_valid", j), 64'(wb_valid), 64'd1);
      chk($sformatf("hold%0d_wb_rd", j),    64'(wb_rd),    64'd5);
      chk($sformatf("hold%0d_wb_value", j), 64'(wb_value), 64'd42);
    end
    hold_drv = 1'b0;
    wb_ready = 1'b1;
    cycle();
    chk("hold_after_pop_valid", 64'(wb_valid), 64'd0);
    chk("hold_after_pop_busy",  64'(busy),     64'd0);
    wb_ready = 1'b0;

    // back-to-back with hold tied to stall: in-order, no loss
    stall_link = 1'b1;
    sb_en      = 1'b1;
    for (int r = 1; r <= 3; r++) exp_q.push_back({5'(r), 32'(r * 10)});
    for (int r = 1; r <= 3; r++) begin
      logic acc;
      acc = 1'b0;
      set_issue(1'b1, INST_MUL, 5'(r), 32'(r), 32'd10);
      for (int t = 0; t < 8 && !acc; t++) begin
        acc = !hold;
        cycle();
      end
      chk($sformatf("b2b_issue%0d_accepted", r), 64'(acc), 64'd1);
    end
    idle();
    for (int t = 0; t < 4; t++) cycle();
    chk("b2b_full_stall", 64'(stall),    64'd1);
    chk("b2b_full_head",  64'(wb_rd),    64'd1);
    chk("b2b_full_busy",  64'(busy),     64'd1);
    wb_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycle();
    chk("b2b_drain_left", 64'(exp_q.size()), 64'd0);
    cycle();
    cycle();
    chk("b2b_end_valid", 64'(wb_valid), 64'd0);
    chk("b2b_end_busy",  64'(busy),     64'd0);
    wb_ready   = 1'b0;
    stall_link = 1'b0;

    // flush: in-flight tags die, buffered entry survives
    exp_q.push_back({5'd11, 32'd4});
    set_issue(1'b1, INST_MUL, 5'd11, 32'd2, 32'd2);
    cycle();
    idle();
    cycle();
    cycle();
    set_issue(1'b1, INST_MUL, 5'd4, 32'd5, 32'd5);
    cycle();
    idle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush1_head_rd", 64'(wb_rd), 64'd11);
    set_issue(1'b1, INST_MUL, 5'd4, 32'd5, 32'd5);
    cycle();
    idle();
    cycle();
    flush    = 1'b1;
    hold_drv = 1'b1;
    cycle();
    flush    = 1'b0;
    hold_drv = 1'b0;
    wb_ready = 1'b1;
    for (int t = 0; t < 6; t++) cycle();
    chk("flush_drain_left", 64'(exp_q.size()), 64'd0);
    chk("flush_end_valid",  64'(wb_valid),     64'd0);
    chk("flush_end_busy",   64'(busy),         64'd0);
    wb_ready = 1'b0;
    sb_en    = 1'b0;

    // RAW scoreboard
    rs1 = 5'd9;
    set_issue(1'b1, INST_MUL, 5'd9, 32'd3, 32'd3);
    cycle();
    chk("hz_stage1", 64'(hazard), 64'(SB_EN));
    idle();
    cycle();
    chk("hz_stage2", 64'(hazard), 64'(SB_EN));
    cycle();
    chk("hz_buffered", 64'(hazard), 64'(SB_EN));
    rs1 = 5'd0;
    #1;
    chk("hz_rs_zero", 64'(hazard), 64'd0);
    rs2 = 5'd9;
    #1;
    chk("hz_rs2", 64'(hazard), 64'(SB_EN));
    rs2 = 5'd0;
    rs1 = 5'd9;
    wb_ready = 1'b1;
    #1;
    chk("hz_popping_head", 64'(hazard), 64'(SB_EN));
    cycle();
    chk("hz_after_pop", 64'(hazard), 64'd0);
    chk("hz_after_pop_valid", 64'(wb_valid), 64'd0);
    wb_ready = 1'b0;

    // asynchronous reset mid-operation
    set_issue(1'b1, INST_MUL, 5'd13, 32'd1, 32'd1);
    cycle();
    set_issue(1'b1, INST_MUL, 5'd14, 32'd2, 32'd2);
    cycle();
    idle();
    cycle();
    chk("pre_rst_valid", 64'(wb_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_wb_rd",    64'(wb_rd),    64'd0);
    chk("arst_wb_value", 64'(wb_value), 64'd0);
    chk("arst_busy",     64'(busy),     64'd0);
    chk("arst_stall",    64'(stall),    64'd0);
    chk("arst_hazard",   64'(hazard),   64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycle();
    cycle();
    chk("post_rst_busy",  64'(busy),     64'd0);
    chk("post_rst_valid", 64'(wb_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_wb_ctrl.md
Name: mul_wb_ctrl

Overview:
- Writeback-side companion of the multiplier; sits directly downstream of it.
- Carries the destination register index of each issued MUL/MULH/MULHSU/MULHU through a tag pipeline that advances exactly as the multiplier datapath does.
- When a tag emerges, captures the multiplier's result into a small result buffer and presents it to the writeback port with a valid/ready handshake.
- Generates a stall request when the buffer is nearly full and, optionally, a RAW hazard indication for the issue stage.

Parameters:
MULT_STAGES  2  multiplier latency in non-held clock edges (2 or 3); must equal the multiplier's setting
FIFO_DEPTH   2  result buffer entries (>=2, power of two)

Ports:
clk_i              in   1   core clock
rstn_i             in   1   asynchronous active-low reset
issue_valid_i      in   1   same signal that drives the multiplier's opcode_valid_i
issue_opcode_i     in   32  same instruction word that drives the multiplier
issue_rd_i         in   5   destination register of the issued instruction
hold_i             in   1   pipeline hold; same net as the multiplier's hold_i
flush_i            in   1   kill all in-flight (not yet captured) multiplies
mul_value_i        in   32  multiplier writeback_value_o
wb_ready_i         in   1   writeback port accepts this cycle
wb_valid_o         out  1   buffered result available
wb_rd_o            out  5   destination of head entry
wb_value_o         out  32  value of head entry
stall_o            out  1   request for the hazard unit to raise hold_i (combinational from state)
busy_o             out  1   any tag in flight or any entry buffered
rs1_i              in   5   issue-stage source 1 (scoreboard only)
rs2_i              in   5   issue-stage source 2 (scoreboard only)
hazard_o           out  1   a source matches a pending rd (scoreboard only)

Behaviour:
- Reset (async, rstn_i low): all tag valids, consumed flag and buffer pointers cleared. wb_valid_o=0, wb_rd_o=0, wb_value_o=0, stall_o=0, busy_o=0, hazard_o=0. Reset mid-operation discards everything.
- Mul decode uses the shared INST_MUL*/MASK constants, exactly matching the multiplier's four-way decode.
- Tag pipe: stages 1..MULT_STAGES, each holding {valid, rd}.
  - Stage 1 loads issue_valid_i && is_mul on a clock edge where hold_i=0.
  - Stage k loads stage k-1 on edges where hold_i=0.
  - All stages freeze while hold_i=1.
  - Stage MULT_STAGES is therefore aligned with mul_value_i.
- Capture:
  - Occurs when the last-stage valid=1 and consumed=0.
  - Writes {rd, mul_value_i} into the buffer and sets consumed.
  - consumed clears on every edge where the pipe advances (hold_i=0). It therefore stays 0 when a capture and an advance happen in the same cycle.
  - Prevents a double capture while the pipe is held.
- rd==0: the tag still flows, but capture discards it (nothing is buffered). consumed is still set.
- flush_i: clears all tag valids and consumed on the next edge. It has priority over hold and over capture of the current last stage. Buffered entries are kept and are still written back.
- Buffer behaviour:
  - FIFO; push on capture, pop when wb_valid_o && wb_ready_i.
  - Push and pop in the same cycle: count unchanged, pointers wrap modulo FIFO_DEPTH.
  - Outputs are driven from the head entry; wb_valid_o = (count != 0).
  - wb_rd_o and wb_value_o hold their last value when empty.
- stall_o = (count >= FIFO_DEPTH-1). The hazard unit ORs stall_o into hold_i combinationally. At most one capture can occur while held, so the buffer never overflows.
- Overflow (push when count==FIFO_DEPTH) is an assertion failure.
- busy_o = any tag valid || count != 0.

Optional Feature:
- Macro MUL_WB_SCOREBOARD_EN.
- Defined: hazard_o=1 when a nonzero rs1_i or rs2_i equals the rd of any valid tag stage or any buffered entry. The match is combinational, and a head entry being popped this cycle still counts as pending.
- Undefined: rs1_i/rs2_i are ignored, hazard_o is tied to 0, and no comparators are built.

Decomposition:
- Shared define.v holds INST_MUL/MULH/MULHSU/MULHU plus masks (already present) and a new REG_ADDR_W=5.
- One natural sub-module: mul_wb_fifo, a parameterised depth/width FIFO with count output. It is instantiated with width 37 ({rd, value}).
- The tag pipe is a generate loop over MULT_STAGES.

Test Plan:
- MUL rd=5, 7*6, no hold, MULT_STAGES=2 → wb_valid_o rises 2 edges after issue with wb_rd_o=5, wb_value_o=42; pop with wb_ready_i=1 → empty, busy_o=0.
- Same issue with hold_i=1 for 3 cycles while the tag is in the last stage → exactly one capture; count=1 throughout; value 42 delivered once.
- Back-to-back MULs rd=1,2,3 with wb_ready_i=0 → stall_o asserts at count=1 (depth 2); the bench drives hold_i=stall_o; count stops at 2; release ready → in-order results 1,2,3 and no loss.
- MUL rd=0 → no wb_valid_o; busy_o drops after MULT_STAGES edges.
- MUL rd=4 issued, flush_i asserted one cycle later → no writeback for rd=4; an entry already buffered before the flush is still written.
- With MUL_WB_SCOREBOARD_EN: MUL rd=9 in flight, rs1_i=9 → hazard_o=1 until the pop edge; rs2_i=0 with any pending rd → hazard_o=0. Without the macro: hazard_o=0 always.
